// File: rtl/fir_mac_sequencer_if.sv
// Bundle between the sample source/coefficient loader and the FIR MAC
// sequencer.
//
// Signals:
//   in_valid/in_ready/in   : sample stream into the filter
//   coef_we/addr/data      : coefficient register write port
//   out_valid/out          : filtered result, out_valid is a one-cycle pulse
//   busy                   : filter is computing (MAC or DONE)
//
// Handshake: a sample transfers on a rising clock edge where both in_valid
// and in_ready are high. The source may raise in_valid at any time and must
// keep in stable while in_valid is high and in_ready is low. in_ready does not
// depend on in_valid. out_valid has no ready; the consumer must take the
// result in the cycle it pulses (out also holds its value afterwards).
interface fir_mac_sequencer_if #(
  parameter int TAPS   = 8,
  parameter int COEF_W = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [31:0]        in;
  logic                      coef_we;
  logic [$clog2(TAPS)-1:0]   coef_addr;
  logic signed [COEF_W-1:0]  coef_data;
  logic                      out_valid;
  logic signed [31:0]        out;
  logic                      busy;

  modport master (
    output in_valid, in, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, in, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: a circular delay line of TAPS samples, a
// coefficient bank, and one shared multiply-accumulate unit sequenced one tap
// per cycle. One sample in, one saturated result out per TAPS+2 cycles.
//
// Ports:
//   clk          : system clock
//   nRst         : asynchronous reset, active-high (1 = in reset)
//   bus          : sample / coefficient / result bundle (slave side)
//   dbg_state_o  : current FSM state (0 IDLE, 1 MAC, 2 DONE)
module fir_mac_sequencer #(
  parameter int TAPS   = 8,
  parameter int COEF_W = 16,
  parameter int SHIFT  = 15,
  parameter int ACC_W  = 32 + COEF_W + $clog2(TAPS)
) (
  input  logic               clk,
  input  logic               nRst,
  fir_mac_sequencer_if.slave bus,
  output logic [1:0]         dbg_state_o
);
  localparam int KW = $clog2(TAPS);
  localparam int PW = 32 + COEF_W;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [31:0]       dline_q [TAPS];
  logic signed [31:0]       dline_d [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [31:0]       out_q, out_d;
  logic                     out_valid_q, out_valid_d;

  logic                     accept;
  logic [KW-1:0]            rd_idx;
  logic signed [PW-1:0]     coef_ext, samp_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, shifted;
  logic [ACC_W-32:0]        upper;
  logic signed [31:0]       sat;

  // in_ready is forced low while reset is held, even though the state
  // register already reads IDLE.
  assign bus.in_ready  = (state_q == S_IDLE) && !nRst;
  assign accept        = bus.in_ready && bus.in_valid;
  assign bus.busy      = (state_q == S_MAC) || (state_q == S_DONE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign dbg_state_o   = state_q;

  // Tap k reads x[n-k]; the pointer subtraction wraps modulo TAPS because
  // TAPS is a power of two.
  assign rd_idx   = wr_ptr_q - k_q;
  assign coef_ext = {{(PW - COEF_W){coef_q[k_q][COEF_W-1]}}, coef_q[k_q]};
  assign samp_ext = {{(PW - 32){dline_q[rd_idx][31]}}, dline_q[rd_idx]};
  assign prod     = coef_ext * samp_ext;
  assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

  // Saturate: the shifted value fits in 32 bits only if all bits from 31 up
  // agree with the sign.
  assign shifted = acc_q >>> SHIFT;
  assign upper   = shifted[ACC_W-1:31];
  always_comb begin
    sat = shifted[31:0];
    if (!((&upper) || !(|upper))) begin
      sat = shifted[ACC_W-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    dline_d     = dline_q;
    coef_d      = coef_q;

    // Writes outside IDLE are dropped so a computation sees stable taps.
    if ((state_q == S_IDLE) && bus.coef_we) begin
      coef_d[bus.coef_addr] = bus.coef_data;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dline_d[wr_ptr_q] = bus.in;
          acc_d             = '0;
          k_d               = '0;
          state_d           = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_d       = sat;
        out_valid_d = 1'b1;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
        coef_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      dline_q     <= dline_d;
      coef_q      <= coef_d;
    end
  end
endmodule
